jump_motion_ctrl: RTL and testbench
===================================

# jump_motion_ctrl

Per-character motion sequencer that drives the character position datapath once per frame. It turns decoded key presses and per-side collision flags into signed per-frame X/Y steps, and runs a jump/gravity state machine: ground, rise, apex, fall. It also generates the walk-animation frame index. One instance sits between the keycode decode and each character's position registers; the datapath adds `dx`/`dy` to its position every `frame_clk`.

## Interface
- `RISE_FRAMES`, 12, number of frames spent rising per jump (≥1)
- `RISE_SPEED`, 5, upward step per rising frame (pixels)
- `FALL_MAX`, 4, terminal fall step (pixels/frame)
- `WALK_SPEED`, 3, horizontal step per frame (pixels)
- `ANIM_DIV`, 5, frames per animation-frame toggle (≥1)

Ports:
- `frame_clk` in 1: frame-rate clock.
- `Reset` in 1: synchronous, active-high.
- `key_up` in 1: jump key held.
- `key_left` in 1: left key held.
- `key_right` in 1: right key held.
- `can_up` in 1: 1 = upward path clear.
- `can_down` in 1: 1 = no floor below.
- `can_left` in 1: 1 = left path clear.
- `can_right` in 1: 1 = right path clear.
- `jump_block` in 1: 1 = jump inhibited (closed gate/platform overhead).
- `dx` out 10: signed two's-complement X step for this frame.
- `dy` out 10: signed two's-complement Y step; negative is up.
- `state` out 2: 00 GROUND, 01 RISE, 10 APEX, 11 FALL.
- `anim_frame` out 2: 00 idle, 01/10 walk frames.
- `moving_left` out 1: `dx` negative.
- `moving_right` out 1: `dx` positive.

## Operation
- **GROUND**
  - `can_down`=1 → FALL, with `fall_v`=1.
  - Else `key_up` & `can_up` & !`jump_block` → RISE, with `rise_cnt`=0.
  - Else stay; `dy`=0.
- **RISE**
  - `dy` = −`RISE_SPEED`; `rise_cnt` increments each frame.
  - `rise_cnt`==`RISE_FRAMES`−1 or `can_up`=0 → APEX.
  - `can_up`=0 forces `dy`=0 on that frame (head bump).
- **APEX**
  - `dy`=0 for exactly one frame → FALL, with `fall_v`=1.
- **FALL**
  - `dy` = +`fall_v`; `fall_v` increments by 1 per frame, saturating at `FALL_MAX`.
  - `can_down`=0 → GROUND with `dy`=0 that frame.
  - `key_up` is ignored (no double jump).
- **Priority:** `can_down`=0 always wins over gravity. GROUND with `can_down`=1 falls even if `key_up` is held.
- **Horizontal step (grounded)**
  - `key_right` & !`key_left` & `can_right` → +`WALK_SPEED`.
  - `key_left` & !`key_right` & `can_left` → −`WALK_SPEED`.
  - Both keys or neither key → 0.
  - Blocked side → 0.
- **Airborne horizontal step:** see Configuration.
- **Animation**
  - 3-bit counter counts frames; on reaching `ANIM_DIV`−1 it wraps to 0.
  - On wrap: if `dx`≠0, `anim_frame` toggles 10↔01 (from 00 it goes to 10); else `anim_frame`=00.
- **Width rule:** all steps are sign-extended to 10 bits; `fall_v` is 3 bits wide.

## Timing
- All outputs are registered.
- `dx`/`dy`/`state` reflect inputs sampled on the same `frame_clk` edge, so there is one frame of latency from key/flag change to step.
- **Reset values:** `state`=GROUND, `dx`=0, `dy`=0, `anim_frame`=00, `moving_*`=0, `rise_cnt`=0, `fall_v`=0, anim counter=0.
- Reset mid-jump aborts immediately to GROUND on the next edge; no residual velocity.
- `moving_left`/`moving_right` are combinational from registered `dx`.
- A jump from a flat floor with no obstruction: 12 RISE frames (−60 px), 1 APEX frame, then FALL with steps 1,2,3,4,4,…

## Configuration
- Macro: `JUMP_AIR_CONTROL_EN`.
- **Defined:** horizontal rules apply identically in RISE/APEX/FALL (steering in air).
- **Undefined:** on leaving GROUND, the current horizontal direction is latched. While airborne, `dx` = latched direction × `WALK_SPEED`, forced to 0 on that frame if the corresponding `can_*` is 0; keys are ignored until GROUND.

## Test plan
- Reset, then `can_down`=0 with no keys → `state`=00, `dx`=`dy`=0, `anim_frame`=00 held 20 frames.
- `key_right`=1, `can_right`=1 on ground → `dx`=+3 from frame 1. `anim_frame` sequence 00 for 4 frames, then 10, 01, 10 every 5 frames; `moving_right`=1.
- `key_up` 1 frame on ground, all clear, `can_down` dropping to 0 after the fall → 12 frames `dy`=−5, 1 frame `dy`=0, then `dy`=1,2,3,4,4; `can_down`=0 → `dy`=0, `state`=00.
- `jump_block`=1 with `key_up`=1 → stays GROUND, `dy`=0. Then `can_up`=0 on RISE frame 3 → APEX next, then FALL.
- Both `key_left` and `key_right` held → `dx`=0, `anim_frame`=00. Reset asserted on FALL frame 2 → all outputs at reset values next edge.
- Without `JUMP_AIR_CONTROL_EN`: jump while holding left, release left mid-air, press right → `dx` stays −3 until landing. With the macro defined, `dx` becomes +3 one frame after the press.

Source files
------------

// File: rtl/jump_motion_ctrl.sv
// jump_motion_ctrl: per-character motion sequencer, one update per frame_clk.
// Turns key presses and collision flags into signed dx/dy steps, runs the
// ground/rise/apex/fall jump state machine and the walk-animation index.
// Optional feature macro: JUMP_AIR_CONTROL_EN (steering while airborne).
module jump_motion_ctrl #(
  parameter int RISE_FRAMES = 12,
  parameter int RISE_SPEED  = 5,
  parameter int FALL_MAX    = 4,
  parameter int WALK_SPEED  = 3,
  parameter int ANIM_DIV    = 5
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       key_up,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       can_up,
  input  logic       can_down,
  input  logic       can_left,
  input  logic       can_right,
  input  logic       jump_block,
  output logic [9:0] dx,
  output logic [9:0] dy,
  output logic [1:0] state,
  output logic [1:0] anim_frame,
  output logic       moving_left,
  output logic       moving_right
);

  localparam int RCW = (RISE_FRAMES > 1) ? $clog2(RISE_FRAMES) : 1;
  localparam logic [RCW-1:0] RISE_LAST = RCW'(RISE_FRAMES - 1);
  localparam logic [9:0]     STEP_R    = 10'(WALK_SPEED);
  localparam logic [9:0]     STEP_L    = 10'(-WALK_SPEED);
  localparam logic [9:0]     STEP_UP   = 10'(-RISE_SPEED);
  localparam logic [2:0]     FV_MAX    = 3'(FALL_MAX);
  localparam logic [2:0]     ANIM_LAST = 3'(ANIM_DIV - 1);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    APEX   = 2'b10,
    FALL   = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [9:0]     dx_q, dx_d, dy_q, dy_d;
  logic [2:0]     fall_v_q, fall_v_d;
  logic [RCW-1:0] rise_cnt_q, rise_cnt_d;
  logic [2:0]     anim_cnt_q, anim_cnt_d;
  logic [1:0]     anim_q, anim_d;
  logic           go_r, go_l;
  logic [9:0]     ground_step;

`ifndef JUMP_AIR_CONTROL_EN
  // direction latched from the keys on the last grounded frame: {left, right}
  logic [1:0]     air_dir_q, air_dir_d;
`endif

  assign state        = state_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign anim_frame   = anim_q;
  assign moving_left  = dx_q[9];
  assign moving_right = ~dx_q[9] & (|dx_q);

  // exactly one horizontal key held; both or neither cancel out
  assign go_r = key_right & ~key_left;
  assign go_l = key_left & ~key_right;

  // walking step with the blocked side forced to zero
  always_comb begin
    ground_step = '0;
    if (go_r && can_right)     ground_step = STEP_R;
    else if (go_l && can_left) ground_step = STEP_L;
  end

  // next-state, vertical/horizontal step and animation logic
  always_comb begin
    state_d    = state_q;
    dy_d       = '0;
    fall_v_d   = fall_v_q;
    rise_cnt_d = rise_cnt_q;
    anim_cnt_d = anim_cnt_q + 3'd1;
    anim_d     = anim_q;

    case (state_q)
      GROUND: begin
        // a missing floor wins over a jump request
        if (can_down) begin
          state_d  = FALL;
          fall_v_d = 3'd1;
          dy_d     = 10'd1;
        end else if (key_up && can_up && !jump_block) begin
          state_d    = RISE;
          rise_cnt_d = '0;
          dy_d       = STEP_UP;
        end
      end
      RISE: begin
        // last rising frame or head bump: stop vertical motion at the apex
        if (rise_cnt_q == RISE_LAST || !can_up) begin
          state_d = APEX;
        end else begin
          rise_cnt_d = rise_cnt_q + RCW'(1);
          dy_d       = STEP_UP;
        end
      end
      APEX: begin
        state_d  = FALL;
        fall_v_d = 3'd1;
        dy_d     = 10'd1;
      end
      FALL: begin
        if (!can_down) begin
          state_d  = GROUND;
          fall_v_d = '0;
        end else begin
          fall_v_d = (fall_v_q >= FV_MAX) ? FV_MAX : fall_v_q + 3'd1;
          dy_d     = {7'd0, fall_v_d};
        end
      end
      default: state_d = GROUND;
    endcase

`ifdef JUMP_AIR_CONTROL_EN
    dx_d = ground_step;
`else
    air_dir_d = air_dir_q;
    if (state_q == GROUND) begin
      dx_d      = ground_step;
      air_dir_d = {go_l, go_r};
    end else begin
      dx_d = '0;
      if (air_dir_q[0] && can_right)     dx_d = STEP_R;
      else if (air_dir_q[1] && can_left) dx_d = STEP_L;
    end
`endif

    // walk frames alternate on each wrap while moving; idle pose otherwise
    if (anim_cnt_q == ANIM_LAST) begin
      anim_cnt_d = '0;
      if (dx_q != '0) anim_d = (anim_q == 2'b10) ? 2'b01 : 2'b10;
      else            anim_d = 2'b00;
    end
  end

  // frame register: every output is registered, sync active-high reset
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q    <= GROUND;
      dx_q       <= '0;
      dy_q       <= '0;
      fall_v_q   <= '0;
      rise_cnt_q <= '0;
      anim_cnt_q <= '0;
      anim_q     <= 2'b00;
`ifndef JUMP_AIR_CONTROL_EN
      air_dir_q  <= 2'b00;
`endif
    end else begin
      state_q    <= state_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      fall_v_q   <= fall_v_d;
      rise_cnt_q <= rise_cnt_d;
      anim_cnt_q <= anim_cnt_d;
      anim_q     <= anim_d;
`ifndef JUMP_AIR_CONTROL_EN
      air_dir_q  <= air_dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_jump_motion_ctrl.sv
// Self-checking bench for jump_motion_ctrl: directed scenarios with literal
// expectations plus randomized frames checked against an integer model.
module tb_jump_motion_ctrl;
  localparam int RF = 12, RS = 5, FM = 4, WS = 3, AD = 5;

  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  logic key_up = 0, key_left = 0, key_right = 0;
  logic can_up = 1, can_down = 0, can_left = 1, can_right = 1, jump_block = 0;
  logic [9:0] dx, dy;
  logic [1:0] state, anim_frame;
  logic moving_left, moving_right;

  always #5 frame_clk = ~frame_clk;

  jump_motion_ctrl #(.RISE_FRAMES(RF), .RISE_SPEED(RS), .FALL_MAX(FM),
                     .WALK_SPEED(WS), .ANIM_DIV(AD)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .key_up(key_up),
    .key_left(key_left), .key_right(key_right), .can_up(can_up),
    .can_down(can_down), .can_left(can_left), .can_right(can_right),
    .jump_block(jump_block), .dx(dx), .dy(dy), .state(state),
    .anim_frame(anim_frame), .moving_left(moving_left),
    .moving_right(moving_right));

  int n_vec = 0, n_bad = 0;
  // model: 0 ground, 1 rise, 2 apex, 3 fall; m_dir -1/0/+1; anim 0/1/2
  int m_st = 0, m_dx = 0, m_dy = 0, m_fv = 0, m_rc = 0, m_ac = 0, m_an = 0, m_dir = 0;
  int exp_jump[19];
  int air_exp;

  function automatic int sdx();
    return int'($signed(dx));
  endfunction
  function automatic int sdy();
    return int'($signed(dy));
  endfunction

  function void chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // advance the model by one frame using the inputs about to be sampled
  task automatic model_step();
    int gs, ndx;
    if (Reset) begin
      m_st = 0; m_dx = 0; m_dy = 0; m_fv = 0; m_rc = 0; m_ac = 0; m_an = 0; m_dir = 0;
      return;
    end
    gs = 0;
    if (key_right && !key_left && can_right)      gs = WS;
    else if (key_left && !key_right && can_left)  gs = -WS;
`ifdef JUMP_AIR_CONTROL_EN
    ndx = gs;
`else
    if (m_st == 0) begin
      ndx = gs;
      m_dir = (key_right && !key_left) ? 1 : (key_left && !key_right) ? -1 : 0;
    end else begin
      ndx = (m_dir > 0 && can_right) ? WS : (m_dir < 0 && can_left) ? -WS : 0;
    end
`endif
    if (m_ac == AD - 1) begin
      m_ac = 0;
      m_an = (m_dx != 0) ? ((m_an == 2) ? 1 : 2) : 0;
    end else m_ac++;
    m_dx = ndx;
    case (m_st)
      0: if (can_down) begin m_st = 3; m_fv = 1; m_dy = 1; end
         else if (key_up && can_up && !jump_block) begin m_st = 1; m_rc = 0; m_dy = -RS; end
         else m_dy = 0;
      1: if (m_rc == RF - 1 || !can_up) begin m_st = 2; m_dy = 0; end
         else begin m_rc++; m_dy = -RS; end
      2: begin m_st = 3; m_fv = 1; m_dy = 1; end
      default: if (!can_down) begin m_st = 0; m_dy = 0; m_fv = 0; end
               else begin m_fv = (m_fv + 1 > FM) ? FM : m_fv + 1; m_dy = m_fv; end
    endcase
  endtask

  // one frame: model, clock edge, then compare every output against the model
  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    chk("state", int'(state), m_st);
    chk("dx", sdx(), m_dx);
    chk("dy", sdy(), m_dy);
    chk("anim_frame", int'(anim_frame), m_an);
    chk("moving_left", int'(moving_left), int'(m_dx < 0));
    chk("moving_right", int'(moving_right), int'(m_dx > 0));
  endtask

  task automatic clr_inputs();
    key_up = 0; key_left = 0; key_right = 0; jump_block = 0;
    can_up = 1; can_down = 0; can_left = 1; can_right = 1;
  endtask

  task automatic do_reset();
    Reset = 1; tick(); Reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 12; i++) exp_jump[i] = -RS;
    exp_jump[12] = 0; exp_jump[13] = 1; exp_jump[14] = 2; exp_jump[15] = 3;
    exp_jump[16] = 4; exp_jump[17] = 4; exp_jump[18] = 0;

    // reset and idle on the floor
    clr_inputs();
    do_reset(); do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_dx", sdx(), 0);
    chk("rst_dy", sdy(), 0);
    chk("rst_anim", int'(anim_frame), 0);
    for (int i = 0; i < 20; i++) tick();
    chk("idle_state", int'(state), 0);
    chk("idle_anim", int'(anim_frame), 0);

    // walking right: animation phase from a fresh reset
    do_reset();
    key_right = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) begin
        chk("walk_dx", sdx(), 3);
        chk("walk_mr", int'(moving_right), 1);
      end
      if (i == 4)  chk("walk_anim4", int'(anim_frame), 0);
      if (i == 5)  chk("walk_anim5", int'(anim_frame), 2);
      if (i == 10) chk("walk_anim10", int'(anim_frame), 1);
      if (i == 15) chk("walk_anim15", int'(anim_frame), 2);
    end

    // full jump profile
    clr_inputs(); do_reset();
    for (int i = 1; i <= 19; i++) begin
      key_up = (i == 1);
      can_down = (i >= 2 && i <= 18);
      tick();
      chk("jump_dy", sdy(), exp_jump[i-1]);
    end
    chk("jump_land_state", int'(state), 0);

    // jump inhibited, then head bump on rise frame 3
    clr_inputs(); do_reset();
    jump_block = 1; key_up = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("blk_state", int'(state), 0);
    chk("blk_dy", sdy(), 0);
    jump_block = 0;
    tick(); key_up = 0; tick(); tick();
    can_up = 0; tick();
    chk("bump_state", int'(state), 2);
    chk("bump_dy", sdy(), 0);
    can_up = 1; can_down = 1; tick();
    chk("bump_fall_state", int'(state), 3);
    chk("bump_fall_dy", sdy(), 1);
    can_down = 0; tick();

    // both keys cancel; reset in the middle of a fall
    clr_inputs(); do_reset();
    key_left = 1; key_right = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("both_dx", sdx(), 0);
    chk("both_anim", int'(anim_frame), 0);
    key_left = 0; can_down = 1;
    tick(); tick();
    chk("fall2_dy", sdy(), 2);
    Reset = 1; tick(); Reset = 0;
    chk("midrst_state", int'(state), 0);
    chk("midrst_dx", sdx(), 0);
    chk("midrst_dy", sdy(), 0);
    chk("midrst_ml", int'(moving_left | moving_right), 0);

    // airborne horizontal behaviour
    clr_inputs(); do_reset();
`ifdef JUMP_AIR_CONTROL_EN
    air_exp = 3;
`else
    air_exp = -3;
`endif
    key_left = 1; key_up = 1; tick();
    chk("air_takeoff_dx", sdx(), -3);
    key_left = 0; key_up = 0; tick();
    key_right = 1; tick();
    chk("air_press_dx", sdx(), air_exp);
    tick();
    chk("air_hold_dx", sdx(), air_exp);
    for (int i = 0; i < 20; i++) tick();
    chk("air_land_state", int'(state), 0);
    chk("air_land_dx", sdx(), 3);

    // randomized frames
    clr_inputs(); do_reset();
    for (int i = 0; i < 3000; i++) begin
      Reset      = ($urandom_range(0, 99) == 0);
      key_up     = ($urandom_range(0, 3) == 0);
      key_left   = ($urandom_range(0, 2) == 0);
      key_right  = ($urandom_range(0, 2) == 0);
      can_up     = ($urandom_range(0, 9) != 0);
      can_left   = ($urandom_range(0, 5) != 0);
      can_right  = ($urandom_range(0, 5) != 0);
      jump_block = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 6) == 0) can_down = ~can_down;
      tick();
    end
    Reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
